// File: rtl/drive_pkg.sv
// Shared steering-code, route-action and sequencer-state definitions.
// Direction control imports the same steering constants.
package drive_pkg;

    localparam logic [3:0] DirProceed     = 4'b0000;
    localparam logic [3:0] DirVeerRight   = 4'b1001;
    localparam logic [3:0] DirHardRight   = 4'b1010;
    localparam logic [3:0] DirNinetyRight = 4'b1011;
    localparam logic [3:0] DirVeerLeft    = 4'b0101;
    localparam logic [3:0] DirHardLeft    = 4'b0110;
    localparam logic [3:0] DirNinetyLeft  = 4'b0111;
    localparam logic [3:0] DirStop        = 4'b1111;

    localparam logic [1:0] ActStraight = 2'b00;
    localparam logic [1:0] ActLeft     = 2'b01;
    localparam logic [1:0] ActRight    = 2'b10;
    localparam logic [1:0] ActHalt     = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StFollow,
        StSettle,
        StPivot,
        StDone
    } state_e;

endpackage

// File: rtl/motor_pwm.sv
// One motor channel: PWM counter with duty/direction latched at period start,
// plus an immediate force-off path that also rearms a fresh period.
module motor_pwm #(
    parameter int unsigned PWM_PERIOD = 100_000,
    parameter int unsigned DW         = $clog2(PWM_PERIOD + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] duty,
    input  logic          dir_in,
    input  logic          force_off,
    output logic          en,
    output logic          dir
);

    localparam logic [DW-1:0] CntLast = DW'(PWM_PERIOD - 1);

    logic [DW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] duty_q, duty_d;
    logic          dir_q, dir_d;
    logic          run_q, run_d;
    logic          en_q, en_d;
    logic [DW-1:0] cnt_nxt;

    always_comb begin
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        run_d   = run_q;
        en_d    = en_q;
        cnt_nxt = cnt_q + DW'(1);
        if (force_off) begin
            cnt_d = '0;
            run_d = 1'b0;
            en_d  = 1'b0;
        end else if (!run_q || (cnt_q == CntLast)) begin
            // Period start: the only point where new duty/direction are taken.
            cnt_d  = '0;
            run_d  = 1'b1;
            duty_d = duty;
            dir_d  = dir_in;
            en_d   = (duty != '0);
        end else begin
            cnt_d = cnt_nxt;
            en_d  = (cnt_nxt < duty_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            duty_q <= '0;
            dir_q  <= 1'b1;
            run_q  <= 1'b0;
            en_q   <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            duty_q <= duty_d;
            dir_q  <= dir_d;
            run_q  <= run_d;
            en_q   <= en_d;
        end
    end

    assign en  = en_q;
    assign dir = dir_q;

endmodule

// File: rtl/drive_sequencer.sv
// Line-following drive sequencer: maps steering codes to per-side PWM and walks a
// programmed route of intersection actions (straight / pivot left / pivot right / halt).
module drive_sequencer
    import drive_pkg::*;
#(
    parameter int unsigned PWM_PERIOD    = 100_000,
    parameter int unsigned DUTY_FULL     = 100_000,
    parameter int unsigned DUTY_VEER     = 70_000,
    parameter int unsigned DUTY_HARD     = 30_000,
    parameter int unsigned SETTLE_CYCLES = 10_000_000,
    parameter int unsigned PIVOT_CYCLES  = 40_000_000,
    parameter int unsigned ROUTE_LEN     = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [3:0]                       DIR,
    input  logic [2*ROUTE_LEN-1:0]           route,
    input  logic                             go,
    output logic                             LEN,
    output logic                             REN,
    output logic                             LDIR,
    output logic                             RDIR,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(ROUTE_LEN+1)-1:0]   leg_idx
);

    localparam int unsigned DW       = $clog2(PWM_PERIOD + 1);
    localparam int unsigned LegW     = $clog2(ROUTE_LEN + 1);
    localparam int unsigned MaxDwell = (SETTLE_CYCLES > PIVOT_CYCLES) ? SETTLE_CYCLES
                                                                      : PIVOT_CYCLES;
    localparam int unsigned TW       = $clog2(MaxDwell + 1);

    localparam logic [TW-1:0] SettleLast = TW'(SETTLE_CYCLES - 1);
    localparam logic [TW-1:0] PivotLast  = TW'(PIVOT_CYCLES - 1);
    localparam logic [DW-1:0] Full       = DW'(DUTY_FULL);
    localparam logic [DW-1:0] Veer       = DW'(DUTY_VEER);
    localparam logic [DW-1:0] Hard       = DW'(DUTY_HARD);

    state_e            state_q, state_d;
    logic [3:0]        dir_q;
    logic              armed_q, armed_d;
    logic              cross_q, cross_d;
    logic [LegW-1:0]   leg_q, leg_d;
    logic [TW-1:0]     tmr_q, tmr_d;
    logic [1:0]        act_q, act_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [2*ROUTE_LEN-1:0] route_sh;
    logic [1:0]             leg_act;
    logic                   force_off;
    logic [DW-1:0]          l_duty, r_duty;
    logic                   l_fwd, r_fwd;

    always_comb begin
        state_d  = state_q;
        armed_d  = armed_q | (dir_q != DirStop);
        cross_d  = cross_q & (dir_q == DirStop);
        leg_d    = leg_q;
        tmr_d    = tmr_q;
        act_d    = act_q;
        route_sh = route >> {leg_q, 1'b0};
        leg_act  = route_sh[1:0];

        unique case (state_q)
            StIdle, StDone: begin
                if (go) begin
                    state_d = StFollow;
                    leg_d   = '0;
                    armed_d = 1'b0;
                    cross_d = 1'b0;
                end
            end
            StFollow: begin
                if ((dir_q == DirStop) && armed_q) begin
                    state_d = StSettle;
                    tmr_d   = '0;
                end
            end
            StSettle: begin
                if (tmr_q == SettleLast) begin
                    tmr_d   = '0;
                    armed_d = 1'b0;
                    if ((leg_q == LegW'(ROUTE_LEN)) || (leg_act == ActHalt)) begin
                        state_d = StDone;
                    end else begin
                        leg_d = leg_q + LegW'(1);
                        act_d = leg_act;
                        if (leg_act == ActStraight) begin
                            state_d = StFollow;
                            cross_d = 1'b1;
                        end else begin
                            state_d = StPivot;
                        end
                    end
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            StPivot: begin
                if (tmr_q == PivotLast) begin
                    tmr_d   = '0;
                    armed_d = 1'b0;
                    state_d = StFollow;
                end else begin
                    tmr_d = tmr_q + TW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StFollow) || (state_d == StSettle) || (state_d == StPivot);
        done_d = (state_d == StDone);
    end

    // Drive command follows the state being entered so the PWM stage sees it one
    // edge early; this keeps the stop-to-off latency at two cycles.
    always_comb begin
        force_off = 1'b1;
        l_duty    = '0;
        r_duty    = '0;
        l_fwd     = 1'b1;
        r_fwd     = 1'b1;
        case (state_d)
            StFollow: begin
                force_off = 1'b0;
                l_duty    = Full;
                r_duty    = Full;
                case (dir_q)
                    DirProceed:     ;
                    DirVeerRight:   r_duty = Veer;
                    DirHardRight:   r_duty = Hard;
                    DirNinetyRight: r_fwd = 1'b0;
                    DirVeerLeft:    l_duty = Veer;
                    DirHardLeft:    l_duty = Hard;
                    DirNinetyLeft:  l_fwd = 1'b0;
                    DirStop:        force_off = !cross_d;
                    default:        force_off = 1'b1;
                endcase
            end
            StPivot: begin
                force_off = 1'b0;
                l_duty    = Full;
                r_duty    = Full;
                l_fwd     = (act_d != ActLeft);
                r_fwd     = (act_d != ActRight);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            dir_q   <= DirProceed;
            armed_q <= 1'b0;
            cross_q <= 1'b0;
            leg_q   <= '0;
            tmr_q   <= '0;
            act_q   <= ActStraight;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dir_q   <= DIR;
            armed_q <= armed_d;
            cross_q <= cross_d;
            leg_q   <= leg_d;
            tmr_q   <= tmr_d;
            act_q   <= act_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    motor_pwm #(
        .PWM_PERIOD (PWM_PERIOD),
        .DW         (DW)
    ) u_pwm_left (
        .clk       (clk),
        .rst       (rst),
        .duty      (l_duty),
        .dir_in    (l_fwd),
        .force_off (force_off),
        .en        (LEN),
        .dir       (LDIR)
    );

    motor_pwm #(
        .PWM_PERIOD (PWM_PERIOD),
        .DW         (DW)
    ) u_pwm_right (
        .clk       (clk),
        .rst       (rst),
        .duty      (r_duty),
        .dir_in    (r_fwd),
        .force_off (force_off),
        .en        (REN),
        .dir       (RDIR)
    );

    assign busy    = busy_q;
    assign done    = done_q;
    assign leg_idx = leg_q;

endmodule

// File: tb/tb_drive_sequencer.sv
// Directed bench for drive_sequencer with short PWM/settle/pivot timings.
module tb_drive_sequencer;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       go    = 1'b0;
    logic [3:0] DIR   = 4'b0000;
    logic [3:0] route = 4'b0000;
    logic       LEN, REN, LDIR, RDIR, busy, done;
    logic [1:0] leg_idx;

    int n_tests = 0;
    int n_fail  = 0;
    int lc, rc;

    always #5 clk = ~clk;

    drive_sequencer #(
        .PWM_PERIOD    (10),
        .DUTY_FULL     (10),
        .DUTY_VEER     (7),
        .DUTY_HARD     (3),
        .SETTLE_CYCLES (5),
        .PIVOT_CYCLES  (8),
        .ROUTE_LEN     (2)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .DIR     (DIR),
        .route   (route),
        .go      (go),
        .LEN     (LEN),
        .REN     (REN),
        .LDIR    (LDIR),
        .RDIR    (RDIR),
        .busy    (busy),
        .done    (done),
        .leg_idx (leg_idx)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic window(output int l, output int r);
        l = 0;
        r = 0;
        repeat (10) begin
            tick();
            l += int'(LEN);
            r += int'(REN);
        end
    endtask

    // Enter an intersection: enables drop two cycles later and stay low through
    // the 5-cycle settle; returns on the cycle the settle exit has taken effect.
    task automatic intersection(input string tag);
        DIR = 4'b1111;
        tick();
        tick();
        check({tag, "_off_at2"}, {30'd0, LEN, REN}, 32'd0);
        check({tag, "_busy"}, busy, 1);
        repeat (4) begin
            tick();
            check({tag, "_settle_off"}, {30'd0, LEN, REN}, 32'd0);
        end
        tick();
    endtask

    initial begin
        // Reset with a go pulse that must be ignored.
        route = 4'b1100;
        go    = 1'b1;
        repeat (3) tick();
        check("rst_len", LEN, 0);
        check("rst_ren", REN, 0);
        check("rst_ldir", LDIR, 1);
        check("rst_rdir", RDIR, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_leg", leg_idx, 0);
        rst = 1'b0;
        go  = 1'b0;
        tick();
        check("idle_busy", busy, 0);
        check("idle_len", LEN, 0);

        // Duty mapping.
        DIR = 4'b1001;
        go  = 1'b1;
        tick();
        go  = 1'b0;
        check("go_busy", busy, 1);
        repeat (12) tick();
        window(lc, rc);
        check("veer_r_left", lc, 10);
        check("veer_r_right", rc, 7);
        DIR = 4'b0110;
        repeat (12) tick();
        window(lc, rc);
        check("hard_l_left", lc, 3);
        check("hard_l_right", rc, 10);
        DIR = 4'b1011;
        repeat (12) tick();
        window(lc, rc);
        check("ninety_r_en", lc + rc, 20);
        check("ninety_r_dirs", {30'd0, LDIR, RDIR}, 32'b10);
        DIR = 4'b0100;
        tick();
        tick();
        check("undef_off", {30'd0, LEN, REN}, 32'd0);
        check("undef_busy", busy, 1);

        // Straight leg then halt leg.
        DIR = 4'b0000;
        repeat (12) tick();
        intersection("straight");
        check("straight_leg", leg_idx, 1);
        check("straight_busy", busy, 1);
        window(lc, rc);
        check("cross_full", lc + rc, 20);
        check("cross_fwd", {30'd0, LDIR, RDIR}, 32'b11);
        DIR = 4'b0000;
        repeat (3) tick();
        intersection("halt");
        check("halt_done", done, 1);
        check("halt_busy", busy, 0);
        check("halt_leg", leg_idx, 1);
        check("halt_off", {30'd0, LEN, REN}, 32'd0);

        // Pivot-left leg.
        rst   = 1'b1;
        tick();
        rst   = 1'b0;
        route = 4'b1101;
        DIR   = 4'b0000;
        go    = 1'b1;
        tick();
        go    = 1'b0;
        repeat (12) tick();
        intersection("pivot");
        check("pivot_dirs", {30'd0, LDIR, RDIR}, 32'b01);
        check("pivot_en", {30'd0, LEN, REN}, 32'b11);
        check("pivot_leg", leg_idx, 1);
        repeat (7) begin
            tick();
            check("pivot_hold", {29'd0, LEN, REN, LDIR}, 32'b110);
        end
        tick();
        check("pivot_exit_busy", busy, 1);
        check("pivot_exit_leg", leg_idx, 1);
        check("pivot_exit_off", {30'd0, LEN, REN}, 32'd0);
        DIR = 4'b0000;
        repeat (12) tick();
        check("after_pivot_fwd", {29'd0, LEN, LDIR, RDIR}, 32'b111);

        // Reset in the middle of a pivot.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        go  = 1'b1;
        tick();
        go  = 1'b0;
        repeat (12) tick();
        intersection("pivot2");
        repeat (3) tick();
        check("pivot2_mid", LDIR, 0);
        rst = 1'b1;
        tick();
        check("midrst_en", {30'd0, LEN, REN}, 32'd0);
        check("midrst_leg", leg_idx, 0);
        check("midrst_busy", busy, 0);
        check("midrst_ldir", LDIR, 1);
        rst = 1'b0;

        // Route exhaustion.
        route = 4'b0000;
        DIR   = 4'b0000;
        go    = 1'b1;
        tick();
        go    = 1'b0;
        repeat (12) tick();
        intersection("ex1");
        check("ex1_leg", leg_idx, 1);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("go_ignored_leg", leg_idx, 1);
        DIR = 4'b0000;
        repeat (5) tick();
        intersection("ex2");
        check("ex2_leg", leg_idx, 2);
        DIR = 4'b0000;
        repeat (5) tick();
        intersection("ex3");
        check("ex3_done", done, 1);
        check("ex3_leg", leg_idx, 2);
        check("ex3_busy", busy, 0);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("restart_leg", leg_idx, 0);
        check("restart_busy", busy, 1);
        check("restart_done", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/drive_sequencer.md
# drive_sequencer

Consumes the 4-bit steering code from the line-following direction control and sequences the two drive motors. In FOLLOW it maps steering codes to per-side PWM duty and motor direction. At each intersection (steering code STOP) it pauses, then executes the next action from a programmed route: straight, pivot left, pivot right, or halt. It sits between direction control and the H-bridge pins.

## Interface
- PWM_PERIOD, 100_000: PWM period in clk cycles (1 kHz at 100 MHz).
- DUTY_FULL, 100_000: on-cycles per period for full drive.
- DUTY_VEER, 70_000: inner-wheel duty for VEER codes.
- DUTY_HARD, 30_000: inner-wheel duty for HARD codes.
- SETTLE_CYCLES, 10_000_000: motor-off dwell at an intersection.
- PIVOT_CYCLES, 40_000_000: pivot duration for a turn action.
- ROUTE_LEN, 8: number of route legs.
- clk, in, 1: system clock.
- rst, in, 1: synchronous, active-high reset.
- DIR, in, 4: steering code. {side[1:0], severity[1:0]}: 0000 PROCEED, 1001/1010/1011 VEER/HARD/NINETY RIGHT, 0101/0110/0111 VEER/HARD/NINETY LEFT, 1111 STOP.
- route, in, 2*ROUTE_LEN: leg i action at route[2i+:2]. 00 straight, 01 left, 10 right, 11 halt.
- go, in, 1: single-cycle start pulse.
- LEN, REN, out, 1 each: left/right motor PWM enable.
- LDIR, RDIR, out, 1 each: motor direction. 1 = forward.
- busy, out, 1: high in every state except IDLE and DONE.
- done, out, 1: high in DONE.
- leg_idx, out, $clog2(ROUTE_LEN+1): index of the next route leg.

## Operation
- **Input registration.** DIR is registered once (dir_q). All decode uses dir_q.
- **IDLE.** Motors off. go moves to FOLLOW, clears leg_idx, and clears `armed`.
- **FOLLOW duty mapping** (left duty / right duty):
  - PROCEED: FULL / FULL.
  - VEER_RIGHT: FULL / VEER.
  - HARD_RIGHT: FULL / HARD.
  - NINETY_RIGHT: FULL fwd / FULL reverse (pivot).
  - Left codes mirror the right codes.
  - Any other code, including 1111 while armed=0: motors off and stay in FOLLOW. Exception: immediately after a straight action, the code is PROCEED until DIR leaves 1111 (see next item).
- **armed flag.** Set when dir_q != 1111. In FOLLOW, dir_q == 1111 with armed=1 goes to SETTLE. After a straight action (armed=0), dir_q == 1111 drives FULL/FULL forward until the robot clears the intersection.
- **SETTLE.** Motors off for SETTLE_CYCLES. Then:
  - If leg_idx == ROUTE_LEN, go to DONE.
  - Otherwise decode route[2*leg_idx+:2]:
    - 00: FOLLOW.
    - 01: PIVOT, L reverse / R forward, FULL.
    - 10: PIVOT, mirrored.
    - 11: DONE.
  - leg_idx increments on every exit from SETTLE except to DONE.
  - armed is cleared on exit.
- **PIVOT.** Runs PIVOT_CYCLES, then goes to FOLLOW with armed=0.
- **DONE.** Motors off; done=1. go restarts as from IDLE.
- go is ignored while busy.
- rst at any time returns to IDLE with all outputs at reset values.
- **Reset values:** LEN=REN=0, LDIR=RDIR=1, busy=0, done=0, leg_idx=0. Internal counters are 0.

## Timing
- PWM counter runs 0..PWM_PERIOD-1 and wraps. Enable is high while cnt < duty. Duty == PWM_PERIOD gives constant high.
- Duty and direction bits are latched only at wrap (cnt == PWM_PERIOD-1 → 0). A new FOLLOW code therefore takes effect at the next period start, which is glitch-free.
- Motors-off (SETTLE, DONE, IDLE, undefined code) forces enables low two cycles after DIR changes (dir_q, then the output register), without waiting for wrap. The counter resets to 0 so the next drive starts a full period.
- The settle/pivot counter counts from 0 and exits on the cycle it equals N-1. Each dwell is therefore exactly N cycles.
- State output registers (busy, done, leg_idx) update on the clock edge of the transition.

## Structure
- Shared package (drive_pkg): DIR code constants (PROCEED, VEER_*, HARD_*, NINETY_*, STOP), route action constants, and the state enum (IDLE, FOLLOW, SETTLE, PIVOT, DONE). Direction control imports the same DIR constants.
- Sub-module motor_pwm: one instance per side. Ports: clk, rst, duty, dir_in, force_off; outputs en and dir. It owns its counter and wrap latching.

## Test plan
Bench parameters: PWM_PERIOD=10, DUTY_FULL=10, DUTY_VEER=7, DUTY_HARD=3, SETTLE_CYCLES=5, PIVOT_CYCLES=8, ROUTE_LEN=2.
- **Reset/idle:** rst high for 3 cycles, with DIR=0000 → LEN=REN=0, LDIR=RDIR=1, busy=0, leg_idx=0; go during rst is ignored.
- **Duty mapping:** after go, DIR=1001 → from the next wrap, LEN high 10/10 cycles and REN 7/10. DIR=0110 → LEN 3/10, REN 10/10.
- **Straight leg:** route=4'b11_00. DIR PROCEED→1111 → enables low within 2 cycles, 5 off cycles, leg_idx=1. Then FULL/FULL while DIR stays 1111; a second 1111 after DIR=0000 → DONE, done=1.
- **Pivot leg:** route legs {01, 11}. Intersection → after settle, LDIR=0, RDIR=1, both FULL for 8 cycles, then FOLLOW with leg_idx=1.
- **Route exhaustion:** route={00,00}, three intersections → third SETTLE exit enters DONE with leg_idx=2. A go pulse restarts with leg_idx=0.
- **Reset mid-pivot:** rst asserted during PIVOT → next cycle IDLE, enables 0, leg_idx 0.
